// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Single-port memory arbiter between a core and a DMA/debug master.
//             Define MEM_ARB_RR_EN for round-robin contention (default: fixed
//             core priority with a DMA starvation guard).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int DMA_MAX_BURST = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic [AW-1:0] core_adr,
  input  logic [DW-1:0] core_wdata,
  input  logic          core_we,
  output logic [DW-1:0] core_rdata,
  output logic          core_wait,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_adr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_we,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1,
    DMA  = 2'd2
  } state_t;

  localparam logic [3:0] BURST_MAX = 4'(DMA_MAX_BURST);

  state_t     state;
  state_t     winner;
  logic [3:0] burst_cnt;
  logic       contend;
  logic       dma_wins_contention;

`ifdef MEM_ARB_RR_EN
  logic last_win_dma;

  assign dma_wins_contention = ~last_win_dma;
`else
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  assign dma_wins_contention = (starve_cnt == STARVE_MAX);
`endif

  // Winner is forced to IDLE under reset so the memory strobe drops at once.
  always_comb begin
    winner  = IDLE;
    contend = 1'b0;
    if (!reset) begin
      winner = IDLE;
    end else if (state == DMA && dma_req && burst_cnt < BURST_MAX) begin
      winner = DMA;
    end else if (dma_req && core_req && burst_cnt == BURST_MAX) begin
      winner = CORE;
    end else if (core_req && !dma_req) begin
      winner = CORE;
    end else if (dma_req && !core_req) begin
      winner = DMA;
    end else if (dma_req && core_req) begin
      contend = 1'b1;
      winner  = dma_wins_contention ? DMA : CORE;
    end
  end

  always_comb begin
    mem_adr   = core_adr;
    mem_wdata = core_wdata;
    mem_we    = 1'b0;
    dma_ack   = 1'b0;
    core_wait = 1'b0;
    case (winner)
      CORE: mem_we = core_we;
      DMA: begin
        mem_adr   = dma_adr;
        mem_wdata = dma_wdata;
        mem_we    = dma_we;
        dma_ack   = 1'b1;
        core_wait = core_req;
      end
      default: ;
    endcase
  end

  assign core_rdata = mem_rdata;
  assign dma_rdata  = mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      burst_cnt <= 4'd0;
`ifdef MEM_ARB_RR_EN
      last_win_dma <= 1'b0;
`else
      starve_cnt   <= 4'd0;
`endif
    end else begin
      state <= winner;

      if (winner == DMA) begin
        if (state != DMA)
          burst_cnt <= 4'd1;
        else if (burst_cnt != BURST_MAX)
          burst_cnt <= burst_cnt + 4'd1;
      end else begin
        burst_cnt <= 4'd0;
      end

`ifdef MEM_ARB_RR_EN
      if (contend)
        last_win_dma <= (winner == DMA);
`else
      // Denied DMA cycles accumulate until a DMA grant; a dropped request keeps the count.
      if (winner == DMA)
        starve_cnt <= 4'd0;
      else if (dma_req && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 4'd1;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Scoreboard bench for mem_arbiter (fixed-priority build).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] CA   = 32'h0000_0040;
  localparam logic [31:0] DA   = 32'h0000_0100;
  localparam logic [31:0] WA   = 32'h0000_0200;
  localparam logic [31:0] CDAT = 32'hDEAD_BEEF;
  localparam logic [31:0] DDAT = 32'h1234_5678;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          core_req = 1'b0;
  logic [AW-1:0] core_adr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          core_we = 1'b0;
  logic [DW-1:0] core_rdata;
  logic          core_wait;
  logic          dma_req = 1'b0;
  logic [AW-1:0] dma_adr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_we = 1'b0;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AW(AW), .DW(DW), .DMA_MAX_BURST(4), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_adr(core_adr), .core_wdata(core_wdata), .core_we(core_we),
    .core_rdata(core_rdata), .core_wait(core_wait),
    .dma_req(dma_req), .dma_adr(dma_adr), .dma_wdata(dma_wdata), .dma_we(dma_we),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Word-addressed memory model: combinational read, write on the rising edge.
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_adr[9:2]];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[DA[9:2]] = DDAT;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_adr[9:2]] <= mem_wdata;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // rsel: 0 = no read-data check, 1 = core_rdata, 2 = dma_rdata
  typedef struct {
    string       tag;
    logic        wt;
    logic        ack;
    logic        we;
    logic [31:0] adr;
    int          rsel;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  function automatic exp_t mk(input string tag, input logic wt, input logic ack, input logic we,
                              input logic [31:0] adr, input int rsel, input logic [31:0] rd);
    exp_t e;
    e.tag = tag; e.wt = wt; e.ack = ack; e.we = we; e.adr = adr; e.rsel = rsel; e.rd = rd;
    return e;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      check_eq({cur.tag, "/core_wait"}, 64'(core_wait), 64'(cur.wt));
      check_eq({cur.tag, "/dma_ack"},   64'(dma_ack),   64'(cur.ack));
      check_eq({cur.tag, "/mem_we"},    64'(mem_we),    64'(cur.we));
      check_eq({cur.tag, "/mem_adr"},   64'(mem_adr),   64'(cur.adr));
      if (cur.rsel == 1) check_eq({cur.tag, "/core_rdata"}, 64'(core_rdata), 64'(cur.rd));
      if (cur.rsel == 2) check_eq({cur.tag, "/dma_rdata"},  64'(dma_rdata),  64'(cur.rd));
    end
  end

  task automatic drive(input logic creq, input logic cwe, input logic [31:0] cadr,
                       input logic [31:0] cwd, input logic dreq, input logic dwe,
                       input logic [31:0] dadr, input logic [31:0] dwd, input exp_t e);
    @(posedge clk);
    #1;
    core_req = creq; core_we = cwe; core_adr = cadr; core_wdata = cwd;
    dma_req = dreq; dma_we = dwe; dma_adr = dadr; dma_wdata = dwd;
    sb.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, mk("idle", 1'b0, 1'b0, 1'b0, 32'h0, 0, 32'h0));
  endtask

  task automatic both(input exp_t e);
    drive(1'b1, 1'b0, CA, 32'h0, 1'b1, 1'b0, DA, 32'h0, e);
  endtask

  task automatic dma_alone(input string tag);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, DA, 32'h0, mk(tag, 1'b0, 1'b1, 1'b0, DA, 2, DDAT));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Requests asserted while in reset must not produce any grant
    core_req = 1'b1; core_we = 1'b1; core_adr = CA; core_wdata = 32'h1;
    dma_req = 1'b1; dma_we = 1'b1; dma_adr = WA; dma_wdata = 32'h2;
    #3;
    check_eq("rst/mem_we",    64'(mem_we),    64'd0);
    check_eq("rst/dma_ack",   64'(dma_ack),   64'd0);
    check_eq("rst/core_wait", 64'(core_wait), 64'd0);
    @(negedge clk);
    check_eq("rst_edge/mem_we", 64'(mem_we), 64'd0);
    core_req = 1'b0; core_we = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
    core_adr = '0; dma_adr = '0;
    #2 reset = 1'b1;
    idle();

    // Lone core write stream
    for (int i = 0; i < 10; i++)
      drive(1'b1, 1'b1, CA, CDAT, 1'b0, 1'b0, 32'h0, 32'h0, mk("core_wr", 1'b0, 1'b0, 1'b1, CA, 0, 32'h0));
    drive(1'b1, 1'b0, CA, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, mk("core_rd", 1'b0, 1'b0, 1'b0, CA, 1, CDAT));

    // Lone DMA read, acked in the same cycle and on the following one
    dma_alone("dma_rd0");
    dma_alone("dma_rd1");
    idle();

    // DMA burst with core joining: 4 DMA acks, then forced yield to core
    dma_alone("burst0");
    for (int i = 0; i < 3; i++) both(mk("burst", 1'b1, 1'b1, 1'b0, DA, 2, DDAT));
    both(mk("yield", 1'b0, 1'b0, 1'b0, CA, 1, CDAT));
    idle();

    // Starvation guard: lone DMA clears the count, then 8 core wins, then DMA
    dma_alone("clr");
    idle();
    for (int i = 0; i < 8; i++) both(mk("starve_core", 1'b0, 1'b0, 1'b0, CA, 1, CDAT));
    for (int i = 0; i < 4; i++) both(mk("starve_dma", 1'b1, 1'b1, 1'b0, DA, 2, DDAT));
    both(mk("starve_yield", 1'b0, 1'b0, 1'b0, CA, 1, CDAT));
    idle();

    // Reset asserted mid-cycle during a DMA write
    @(posedge clk);
    #1;
    core_req = 1'b0; dma_req = 1'b1; dma_we = 1'b1; dma_adr = WA; dma_wdata = 32'hCAFE_F00D;
    #2;
    check_eq("abort_pre/dma_ack", 64'(dma_ack), 64'd1);
    check_eq("abort_pre/mem_we",  64'(mem_we),  64'd1);
    #1 reset = 1'b0;
    #1;
    check_eq("abort/mem_we",  64'(mem_we),  64'd0);
    check_eq("abort/dma_ack", 64'(dma_ack), 64'd0);
    @(posedge clk);
    #1;
    check_eq("abort/mem", 64'(mem[WA[9:2]]), 64'd0);
    dma_req = 1'b0; dma_we = 1'b0; dma_adr = '0; dma_wdata = '0;
    #3 reset = 1'b1;
    // From IDLE with a cleared starve count the core wins contention
    both(mk("post_rst", 1'b0, 1'b0, 1'b0, CA, 1, CDAT));
    idle();
    @(posedge clk);
    #1;
    check_eq("post_rst/mem", 64'(mem[WA[9:2]]), 64'd0);

    repeat (2) @(posedge clk);
    check_eq("sb_drain", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
